// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and debounce default.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_LAP  = 2'b10,
    S_STOP = 2'b11
  } sw_state_e;

  // 10 ms of stable input at 100 MHz
  localparam int DB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability-count debounce and
// rising-edge press pulse, DB_CYCLES+3 clocks after a clean raw rising edge.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Level is accepted on the DB_CYCLES-th consecutive sample that differs from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop and lap/reset buttons, lap latch,
// counter enable/clear and display selection.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic        tick,
  input  logic [15:0] count_bcd,
  input  logic        at_max,
  output logic        count_en,
  output logic        count_clr,
  output logic [15:0] disp_bcd,
  output logic [1:0]  state,
  output logic        lap_active
);

  logic        ss_press;
  logic        lr_press;
  sw_state_e   fsm_state;
  logic [15:0] lap_value;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_ss),
    .press (ss_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_lr (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lr),
    .press (lr_press)
  );

  // Priority in every state: at_max, then ss, then lr (a coincident lr is dropped).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state <= S_IDLE;
      lap_value <= 16'h0000;
      count_clr <= 1'b0;
    end else begin
      count_clr <= 1'b0;
      case (fsm_state)
        S_IDLE: begin
          if (ss_press) fsm_state <= S_RUN;
        end
        S_RUN: begin
          if (at_max || ss_press) begin
            fsm_state <= S_STOP;
          end else if (lr_press) begin
            fsm_state <= S_LAP;
            lap_value <= count_bcd;
          end
        end
        S_LAP: begin
          if (at_max || ss_press) fsm_state <= S_STOP;
          else if (lr_press)      fsm_state <= S_RUN;
        end
        S_STOP: begin
          if (ss_press) begin
            fsm_state <= S_RUN;
          end else if (lr_press) begin
            fsm_state <= S_IDLE;
            count_clr <= 1'b1;
          end
        end
        default: fsm_state <= S_IDLE;
      endcase
    end
  end

  assign state      = fsm_state;
  assign lap_active = (fsm_state == S_LAP);
  assign count_en   = tick & ((fsm_state == S_RUN) | (fsm_state == S_LAP)) & ~at_max;
  assign disp_bcd   = (fsm_state == S_LAP) ? lap_value : count_bcd;

endmodule
